// File: rtl/rgbw_pkg.sv
// Shared types and constants for the RGBW frame decoder.
package rgbw_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_MODE,
        ST_CHECK
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'h55;

    // Default channel order within a frame
    localparam int unsigned CH_LINT      = 0;
    localparam int unsigned CH_COLOR_IDX = 1;
    localparam int unsigned CH_RED       = 2;
    localparam int unsigned CH_GREEN     = 3;
    localparam int unsigned CH_BLUE      = 4;
    localparam int unsigned CH_WHITE     = 5;

endpackage

// File: rtl/rgbw_rdy_edge.sv
// Two-flop synchroniser for the SPI byte-ready strobe plus rising-edge detect.
// All flops hold while clk_half is high.
module rgbw_rdy_edge (
    input  logic clk,
    input  logic reset,
    input  logic clk_half,
    input  logic rdy,
    output logic byte_ev
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronise rdy and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else if (!clk_half) begin
            sync1 <= rdy;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Stays high across held cycles, so the event is consumed on the next enabled edge
    assign byte_ev = sync2 & ~prev;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// Frame decoder: hunts for a sync byte, collects NUM_CH channels and a mode byte,
// optionally verifies an XOR checksum, and commits all channels atomically.
module rgbw_frame_decoder
    import rgbw_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 6,
    parameter int unsigned       DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_DEFAULT),
    parameter bit                CHK_EN      = 1'b1,
    parameter int unsigned       TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_half,
    input  logic [DATA_W-1:0]        buffRx_spi,
    input  logic                     rdy,
    output logic [NUM_CH*DATA_W-1:0] ch_out,
    output logic [DATA_W-1:0]        mode_out,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);
    localparam logic [CW-1:0] TO_LAST  = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] chk;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [DATA_W-1:0] shadow_mode;
    logic              byte_ev;

    rgbw_rdy_edge u_rdy_edge (
        .clk      (clk),
        .reset    (reset),
        .clk_half (clk_half),
        .rdy      (rdy),
        .byte_ev  (byte_ev)
    );

    // Frame FSM, shadow capture, commit and inter-byte timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HUNT;
            idx         <= '0;
            chk         <= '0;
            cnt         <= '0;
            shadow_mode <= '0;
            for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
            ch_out      <= '0;
            mode_out    <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else if (clk_half) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (byte_ev) begin
                // A byte arriving on the expiry cycle wins over the timeout
                cnt <= '0;
                case (state)
                    ST_HUNT: begin
                        if (buffRx_spi == SYNC_BYTE) begin
                            state <= ST_PAYLOAD;
                            idx   <= '0;
                            chk   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow[idx] <= buffRx_spi;
                        chk         <= chk ^ buffRx_spi;
                        if (idx == IDX_LAST) state <= ST_MODE;
                        else                 idx   <= idx + 1'b1;
                    end
                    ST_MODE: begin
                        shadow_mode <= buffRx_spi;
                        chk         <= chk ^ buffRx_spi;
                        if (CHK_EN) begin
                            state <= ST_CHECK;
                        end else begin
                            for (int k = 0; k < NUM_CH; k++) ch_out[k*DATA_W +: DATA_W] <= shadow[k];
                            mode_out <= buffRx_spi;
                            frame_ok <= 1'b1;
                            state    <= ST_HUNT;
                            busy     <= 1'b0;
                        end
                    end
                    ST_CHECK: begin
                        if (buffRx_spi == chk) begin
                            for (int k = 0; k < NUM_CH; k++) ch_out[k*DATA_W +: DATA_W] <= shadow[k];
                            mode_out <= shadow_mode;
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_HUNT;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != ST_HUNT) begin
                if ((TIMEOUT_CYC != 0) && (cnt == TO_LAST)) begin
                    frame_err <= 1'b1;
                    state     <= ST_HUNT;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
